// File: rtl/output_unit_pkg.sv
// output_unit_pkg: flit field layout, TYPE encodings, queue depths and state types for the output unit.
package output_unit_pkg;
    localparam int FLIT_SIZE  = 64;
    localparam int TYPEW      = 2;
    localparam int DSTW       = 9;
    localparam int CHECKW     = 8;
    localparam int PAYW       = FLIT_SIZE - TYPEW - DSTW - CHECKW;
    localparam int PAY_LSB    = 0;
    localparam int CHECK_LSB  = PAY_LSB + PAYW;
    localparam int DST_LSB    = CHECK_LSB + CHECKW;
    localparam int TYPE_LSB   = DST_LSB + DSTW;
    localparam int NCHUNK     = (PAYW + CHECKW - 1) / CHECKW;
    localparam int IN_Q_SIZE  = 8;
    localparam int OUT_Q_SIZE = 2;
    localparam int CREDW      = 4;

    typedef logic [FLIT_SIZE-1:0] flit_t;
    typedef enum logic [1:0] {SINGLE = 2'b00, HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11} flit_type_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} pkt_state_t;
endpackage

// File: rtl/output_unit_if.sv
// output_unit_if: crossbar-to-output flit handshake plus the downstream link (flit out, credit return).
//   in_data/in_valid/in_ready : valid/ready flit input from the crossbar
//   data_out/valid_out        : flit and one-cycle strobe toward the downstream input unit
//   credit_in                 : one pulse per flit freed downstream
interface output_unit_if;
    import output_unit_pkg::*;
    flit_t in_data;
    logic  in_valid;
    logic  in_ready;
    flit_t data_out;
    logic  valid_out;
    logic  credit_in;
    modport master (output in_data, in_valid, credit_in, input in_ready, data_out, valid_out);
    modport slave  (input in_data, in_valid, credit_in, output in_ready, data_out, valid_out);
endinterface

// File: rtl/output_unit_buffer.sv
// output_unit_buffer: show-ahead synchronous FIFO used as the output staging queue.
//   clk, rst (async, active-low), wr_en/din push, rd_en pop, dout = head entry, full/empty flags.
module output_unit_buffer #(
    parameter int buffer_width = 64,
    parameter int buffer_depth = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [buffer_width-1:0] din,
    input  logic                    rd_en,
    output logic [buffer_width-1:0] dout,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = buffer_depth > 1 ? $clog2(buffer_depth) : 1;

    logic [buffer_width-1:0] mem [buffer_depth];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    wr, rd;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(buffer_depth - 1) ? '0 : p + 1'b1;
    endfunction

    assign full  = count == (AW+1)'(buffer_depth);
    assign empty = count == '0;
    assign wr    = wr_en & !full;
    assign rd    = rd_en & !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? inc(wr_ptr) : wr_ptr;
            rd_ptr <= rd ? inc(rd_ptr) : rd_ptr;
            count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/output_unit.sv
// output_unit: transmit side of a router link -- stages flits, stamps CHECK, sends under credit flow control.
//   clk, rst (async, active-low)
//   link       : slave side of output_unit_if (crossbar input, downstream flit output, credit return)
//   credit_cnt : credits currently available downstream
//   locked     : multi-flit packet in progress on the input side
//   pkt_err    : sticky, illegal TYPE sequence seen
//   credit_err : sticky, credit returned while already at full count
module output_unit
    import output_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output_unit_if.slave       link,
    output logic [CREDW-1:0]   credit_cnt,
    output logic               locked,
    output logic               pkt_err,
    output logic               credit_err
);
    logic       push, send, fifo_full, fifo_empty, credit_top, sat, bad;
    flit_t      head;
    flit_type_t ftype;
    pkt_state_t state_q, state_d;
    logic [CREDW-1:0] credit_d;

    // CHECK is the XOR of all CHECKW-bit payload chunks, top chunk zero-padded.
    function automatic flit_t stamp(input flit_t f);
        logic [NCHUNK*CHECKW-1:0] p;
        logic [CHECKW-1:0]        c;
        p = {{(NCHUNK*CHECKW-PAYW){1'b0}}, f[PAY_LSB +: PAYW]};
        c = '0;
        for (int i = 0; i < NCHUNK; i++) c ^= p[i*CHECKW +: CHECKW];
        stamp = f;
        stamp[CHECK_LSB +: CHECKW] = c;
    endfunction

    // Ready follows the full flag only, so a full FIFO blocks accept even on a pop cycle.
    assign link.in_ready = rst & !fifo_full;
    assign push          = link.in_valid & link.in_ready;
    assign send          = !fifo_empty && credit_cnt != '0;
    assign credit_top    = credit_cnt == CREDW'(IN_Q_SIZE);
    assign sat           = link.credit_in & !send & credit_top;
    assign credit_d      = (send & !link.credit_in) ? credit_cnt - 1'b1 :
                           (link.credit_in & !send & !credit_top) ? credit_cnt + 1'b1 : credit_cnt;
    assign locked        = state_q == BUSY;

    output_unit_buffer #(.buffer_width(FLIT_SIZE), .buffer_depth(OUT_Q_SIZE)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   (link.in_data),
        .rd_en (send),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Packet framing tracks accepted flits; bad flits are flagged but still forwarded.
    always_comb begin
        ftype   = flit_type_t'(link.in_data[TYPE_LSB +: TYPEW]);
        state_d = state_q;
        bad     = 1'b0;
        if (push) begin
            state_d = state_q == IDLE ? (ftype == HEAD ? BUSY : IDLE) : (ftype == TAIL ? IDLE : BUSY);
            bad     = state_q == IDLE ? (ftype == BODY || ftype == TAIL) : (ftype == HEAD || ftype == SINGLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link.data_out  <= '0;
            link.valid_out <= 1'b0;
            credit_cnt     <= CREDW'(IN_Q_SIZE);
            credit_err     <= 1'b0;
            pkt_err        <= 1'b0;
            state_q        <= IDLE;
        end else begin
            link.valid_out <= send;
            if (send) link.data_out <= stamp(head);
            credit_cnt     <= credit_d;
            credit_err     <= credit_err | sat;
            pkt_err        <= pkt_err | bad;
            state_q        <= state_d;
        end
    end
endmodule

// File: doc/output_unit.md
Name: output_unit

Overview:
- Transmit side of the router-to-router link.
- Takes flits from the crossbar switch, stages them in a small FIFO and stamps the CHECK field.
- Sends flits to the downstream router's input unit under credit-based flow control.
- Tracks packet boundaries so the switch allocator can hold the output locked for multi-flit packets.

Parameters:
- FLIT_SIZE, 64: flit width (TYPE | DST | CHECK | PAYLOAD, TYPE at MSBs).
- IN_Q_SIZE, 8: depth of the downstream input queue; initial credit count.
- OUT_Q_SIZE, 2: depth of the local staging FIFO.
- CREDW, 4: credit counter width; must satisfy 2^CREDW > IN_Q_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_data  in  FLIT_SIZE  flit from the crossbar.
- in_valid  in  1  in_data valid.
- in_ready  out  1  staging FIFO can accept.
- data_out  out  FLIT_SIZE  flit to downstream input unit.
- valid_out  out  1  one-cycle pulse per flit.
- credit_in  in  1  one pulse per flit dequeued downstream.
- credit_cnt  out  CREDW  credits currently available.
- locked  out  1  packet in progress; allocator must not grant other inputs.
- pkt_err  out  1  sticky: illegal TYPE sequence.
- credit_err  out  1  sticky: credit overflow.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; valid_out=0; data_out=0; credit_cnt=IN_Q_SIZE; FSM=IDLE; locked=0; pkt_err=0; credit_err=0.
  - in_ready forced 0 while rst=0. A flit in flight mid-reset is dropped; no partial state survives.
- Accept:
  - in_ready = rst & !fifo_full.
  - A flit is accepted on a rising edge with in_valid & in_ready.
  - in_valid while in_ready=0 is held by the sender (valid/ready semantics).
- Send:
  - Condition at each edge: FIFO non-empty and credit_cnt>0.
  - On send, pop the head into the data_out register; valid_out=1 for that cycle, else 0. data_out holds its last value when valid_out=0.
  - Minimum latency: accepted at edge k into an empty FIFO with credit -> sent at edge k+1.
  - Throughput: 1 flit/cycle while credits last.
- CHECK stamping:
  - PAYLOAD is split into CHECKW-bit chunks; the top chunk is zero-padded.
  - CHECK = XOR of all chunks, written into every outgoing flit. TYPE, DST and PAYLOAD pass unchanged.
- Credits:
  - Send only: credit_cnt-1. credit_in only: credit_cnt+1. Both in the same cycle: unchanged.
  - credit_cnt never goes below 0 because send is gated.
  - credit_in at credit_cnt==IN_Q_SIZE with no send: counter saturates, credit_err set (sticky until reset).
- Packet FSM, advanced on accepted flits (input side):
  - TYPE encodings: 00 SINGLE, 01 HEAD, 10 BODY, 11 TAIL.
  - IDLE: HEAD -> BUSY; SINGLE -> IDLE; BODY or TAIL -> pkt_err, stay IDLE.
  - BUSY: BODY -> BUSY; TAIL -> IDLE; HEAD or SINGLE -> pkt_err, stay BUSY.
  - locked = (state==BUSY), combinational from state.
  - Errored flits are still forwarded; no flit is ever dropped except by reset.
- Simultaneous accept and send with the FIFO full: accept is blocked because in_ready is computed from the full flag, not from pop.

Decomposition:
- para.v holds: FLIT_SIZE, TYPEW=2, DSTW=9 (3-bit X/Y/Z), CHECKW=8, field LSB positions, the TYPE encodings above, IN_Q_SIZE.
- Staging FIFO reuses the existing buffer module with buffer_width=FLIT_SIZE and buffer_depth=OUT_Q_SIZE; usedw is left unused.
- Checksum is a combinational function in the module body. FSM and credit counter live in output_unit.

Test Plan:
- Reset: release rst with no input -> credit_cnt=8, valid_out=0, in_ready=1, locked=0, both error flags 0.
- SINGLE flit with PAYLOAD 0x0000_1234_5678, no credit returns -> valid_out one cycle after the accept edge; CHECK=0x12^0x34^0x56^0x78=0x08; credit_cnt=7.
- Credit exhaustion: stream 12 SINGLE flits with no credit_in -> exactly 8 sent, credit_cnt=0, FIFO fills, in_ready=0. Then one credit_in pulse -> one more flit sent and credit_cnt returns to 0.
- Packet lock: HEAD, BODY, BODY, TAIL -> locked goes 1 after the HEAD accept edge and 0 after the TAIL accept edge; pkt_err=0. Then BODY in IDLE -> pkt_err=1, flit still sent.
- Simultaneous send and credit_in at credit_cnt=5 -> stays 5. credit_in at credit_cnt=8 with idle FIFO -> stays 8, credit_err=1.
- Reset mid-packet: assert rst after HEAD+BODY with 2 flits queued -> immediately valid_out=0, locked=0, FIFO empty; after release credit_cnt=8.
